inta_sequencer: RTL
===================

# inta_sequencer

CPU-side initiator of the 8259 interrupt-acknowledge handshake. It watches the PIC's INT line and, when the CPU has interrupts enabled, drives two active-low INTA pulses. It also drives the matching 2-bit acknowledge count that the PIC interrupt block uses as `intAcounter`. The vector byte is sampled from the data bus during the second pulse and delivered to the CPU core over a valid/ready handshake.

## Interface
Parameters:
- PULSE_W, default 2, cycles inta_n is held low per pulse; legal range 1..15.
- GAP_W, default 2, cycles inta_n is high between the two pulses; legal range 1..15.

Ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- int_req  in  1  INT from the PIC block, level, same clock domain.
- if_en  in  1  CPU interrupt-enable flag; a request is accepted only while high.
- inta_n  out  1  active-low acknowledge to the PIC; registered.
- ack_count  out  2  acknowledge phase to the PIC: 00 idle, 01 first pulse plus gap, 10 second pulse; registered.
- data_in  in  8  vector byte driven by the PIC.
- vec_valid  out  1  vector available to the CPU.
- vec_data  out  8  captured vector.
- vec_spur  out  1  int_req was low at sample time, so the vector is the default IR7 (spurious) vector.
- vec_ready  in  1  CPU accepts the vector.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, P1, GAP, P2, HOLD. A 4-bit down-counter times P1, GAP and P2.
- IDLE → P1 when int_req & if_en; the counter loads PULSE_W-1.
- P1 → GAP when the counter is 0; the counter loads GAP_W-1.
- GAP → P2 when the counter is 0; the counter loads PULSE_W-1.
- P2 → HOLD when the counter is 0. On that same edge, data_in is captured into vec_data and ~int_req into vec_spur.
- HOLD → IDLE on vec_valid & vec_ready.
- inta_n is 0 in P1 and P2, and 1 everywhere else.
- ack_count is 01 in P1 and GAP, 10 in P2, and 00 in IDLE and HOLD.
- vec_valid is 1 only in HOLD.
- vec_data and vec_spur stay stable from HOLD entry until the transfer, and then hold their last value.
- Once P1 is entered, the sequence always completes. A drop of int_req or if_en mid-sequence does not abort it; that case is reported via vec_spur.
- No new sequence starts while in HOLD, so backpressure from vec_ready stalls further acknowledges.
- After a transfer, IDLE is occupied for at least one cycle before P1 can be re-entered. This gives the PIC one cycle to update INT after its ISR changes.

## Timing
- Reset values: inta_n=1, ack_count=00, vec_valid=0, vec_data=8'h00, vec_spur=0, busy=0, state IDLE, counter 0.
- Reset assertion mid-sequence forces inta_n high immediately (asynchronously), with no partial pulse.
- Taking request cycle 0 as the cycle in which IDLE samples int_req & if_en high:
  - P1 (inta_n low) occupies cycles 1..PULSE_W.
  - GAP occupies the next GAP_W cycles.
  - P2 occupies the next PULSE_W cycles.
  - vec_valid rises in cycle 2*PULSE_W+GAP_W+1.
- Capture happens at the final edge of P2. The PIC must hold data_in valid throughout the last P2 cycle.
- Simultaneous vec_valid & vec_ready: transfer occurs and the state is IDLE next cycle. A request present in that IDLE cycle gives P1 the cycle after.
- PULSE_W=1 or GAP_W=1: each phase lasts exactly one cycle; the counter loads 0.

## Structure
- Shared package pic_pkg holds:
  - the state enum (IDLE, P1, GAP, P2, HOLD);
  - ACK_IDLE=2'b00, ACK_FIRST=2'b01, ACK_SECOND=2'b10, which the PIC interrupt block also uses to decode intAcounter;
  - SPURIOUS_IR=3'd7.
- No sub-module. The phase counter is a few lines, and splitting it out adds ports without reuse.

## Test plan
- PULSE_W=2, GAP_W=2; int_req=1 and if_en=1 at cycle 0; data_in=8'h4B during P2:
  - inta_n low in cycles 1-2 and 5-6;
  - ack_count=01 in cycles 1-4 and 10 in cycles 5-6;
  - vec_valid=1 from cycle 7 with vec_data=8'h4B, vec_spur=0.
- if_en=0 with int_req=1 for 20 cycles: inta_n stays 1, busy stays 0, ack_count stays 00.
- int_req drops in GAP; data_in=8'h4F: both pulses still complete; vec_data=8'h4F, vec_spur=1.
- vec_ready held 0 for 10 cycles after vec_valid:
  - vec_valid and vec_data stay stable;
  - with int_req held high, no inta_n pulse occurs until one cycle after the transfer.
- rst_n asserted in cycle 5 (during P2): inta_n=1 and ack_count=00 asynchronously, vec_valid=0; after release, a fresh request restarts from P1.
- PULSE_W=1, GAP_W=1: inta_n low in cycles 1 and 3; vec_valid in cycle 4.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 interrupt-acknowledge path: sequencer states
// and the acknowledge-phase codes the PIC decodes as intAcounter.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    GAP  = 3'd2,
    P2   = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam logic [1:0] ACK_IDLE   = 2'b00;
  localparam logic [1:0] ACK_FIRST  = 2'b01;
  localparam logic [1:0] ACK_SECOND = 2'b10;

  localparam logic [2:0] SPURIOUS_IR = 3'd7;

endpackage

// File: rtl/inta_sequencer.sv
// CPU-side INTA handshake: two timed active-low pulses to the PIC, vector byte
// captured on the last edge of the second pulse and handed over by valid/ready.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       int_req,
  input  logic       if_en,
  output logic       inta_n,
  output logic [1:0] ack_count,
  input  logic [7:0] data_in,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       vec_spur,
  input  logic       vec_ready,
  output logic       busy
);

  localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LD   = 4'(GAP_W - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_cnt_zero;
  logic       w_capture;

  logic       r_inta_n;
  logic [1:0] r_ack;
  logic       r_vld;
  logic [7:0] r_vec_data;
  logic       r_vec_spur;

  logic       w_inta_n_nxt;
  logic [1:0] w_ack_nxt;
  logic       w_vld_nxt;

  assign w_cnt_zero = (r_cnt == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (int_req && if_en) begin
          w_state_nxt = P1;
          w_cnt_nxt   = PULSE_LD;
        end
      end
      P1: begin
        if (w_cnt_zero) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = GAP_LD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = P2;
          w_cnt_nxt   = PULSE_LD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      P2: begin
        if (w_cnt_zero) begin
          w_state_nxt = HOLD;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      HOLD: begin
        if (r_vld && vec_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register cycle for cycle.
  always_comb begin
    w_inta_n_nxt = 1'b1;
    w_ack_nxt    = ACK_IDLE;
    w_vld_nxt    = 1'b0;
    case (w_state_nxt)
      P1: begin
        w_inta_n_nxt = 1'b0;
        w_ack_nxt    = ACK_FIRST;
      end
      GAP:  w_ack_nxt = ACK_FIRST;
      P2: begin
        w_inta_n_nxt = 1'b0;
        w_ack_nxt    = ACK_SECOND;
      end
      HOLD: w_vld_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_inta_n   <= 1'b1;
      r_ack      <= ACK_IDLE;
      r_vld      <= 1'b0;
      r_vec_data <= 8'h00;
      r_vec_spur <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_inta_n <= w_inta_n_nxt;
      r_ack    <= w_ack_nxt;
      r_vld    <= w_vld_nxt;
      if (w_capture) begin
        r_vec_data <= data_in;
        r_vec_spur <= ~int_req;
      end
    end
  end

  assign inta_n    = r_inta_n;
  assign ack_count = r_ack;
  assign vec_valid = r_vld;
  assign vec_data  = r_vec_data;
  assign vec_spur  = r_vec_spur;
  assign busy      = (r_state != IDLE);

endmodule
